// File: rtl/instr_encoder.sv
// Packs one RV32I instruction request per handshake and writes it to consecutive words of instruction memory.
// Latency: accept -> ENC (1 cycle) -> mem_we on the 2nd cycle after accept; 3 cycles per word with mem_ack tied high.
// Backpressure: in_ready is low outside IDLE; mem_we is held with stable addr/data until mem_ack; FULL blocks until restart.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [20:0] in_imm,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        err,
    output logic        full
);

    typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} state_t;

    localparam logic [6:0]  OPC_R    = 7'b0110011;
    localparam logic [6:0]  OPC_IMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD = 7'b0000011;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;
    localparam logic [6:0]  OPC_ST   = 7'b0100011;
    localparam logic [6:0]  OPC_BR   = 7'b1100011;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [15:0] DEPTH_W  = 16'(DEPTH);

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [20:0] imm_q;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        imm12_ok, imm13_ok;
    logic [15:0] count_inc;

    assign in_ready  = (state == IDLE);
    assign mem_we    = (state == WRITE);
    assign full      = (state == FULL);
    assign count_inc = count + 16'd1;

    // Range checks as sign-extension tests on the upper bits of the 21-bit immediate.
    assign imm12_ok = (&imm_q[20:11]) | ~(|imm_q[20:11]);
    assign imm13_ok = ((&imm_q[20:12]) | ~(|imm_q[20:12])) & ~imm_q[0];

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (op_q)
            4'd0: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OPC_R};
            4'd1: enc_word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, OPC_R};
            4'd2: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, OPC_R};
            4'd3: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, OPC_R};
            4'd4: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, OPC_R};
            4'd5: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b010, rd_q, OPC_R};
            4'd6: begin
                enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_IMM};
                enc_legal = imm12_ok;
            end
            4'd7: begin
                enc_word  = {imm_q[11:0], rs1_q, 3'b010, rd_q, OPC_LOAD};
                enc_legal = imm12_ok;
            end
            4'd8: begin
                enc_word  = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OPC_ST};
                enc_legal = imm12_ok;
            end
            4'd9: begin
                enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                             imm_q[4:1], imm_q[11], OPC_BR};
                enc_legal = imm13_ok;
            end
            4'd10: begin
                enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b001,
                             imm_q[4:1], imm_q[11], OPC_BR};
                enc_legal = imm13_ok;
            end
            4'd11: begin
                enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
                enc_legal = ~imm_q[0];
            end
            4'd12: begin
                enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
                enc_legal = imm12_ok;
            end
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ENC;
            ENC:     state_nxt = enc_legal ? WRITE : IDLE;
            WRITE:   if (mem_ack) state_nxt = (count_inc == DEPTH_W) ? FULL : IDLE;
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
        endcase
        if (restart) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            op_q      <= 4'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            imm_q     <= 21'd0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0;
            count     <= 16'd0;
            err       <= 1'b0;
        end else if (restart) begin
            mem_addr <= BASE_ADDR;
            count    <= 16'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= in_op;
                    rd_q  <= in_rd;
                    rs1_q <= in_rs1;
                    rs2_q <= in_rs2;
                    imm_q <= in_imm;
                end
                ENC: begin
                    if (enc_legal) mem_wdata <= enc_word;
                    else           err       <= 1'b1;
                end
                WRITE: if (mem_ack) begin
                    count    <= count_inc;
                    mem_addr <= mem_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, stall, illegal, full and restart/reset cases.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst, restart, in_valid, in_ready, mem_we, mem_ack, err, full;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] count;
    int          n_total = 0;
    int          n_bad   = 0;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .err(err), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ENC cycle.
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [20:0] imm);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_we(output int k);
        k = 1;
        while (!mem_we && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic write_one(input string tag, input logic [3:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input int exp_count);
        int k;
        send(op, rd, rs1, rs2, imm);
        wait_we(k);
        check({tag, "_lat"}, k, 32'd2);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_data"}, mem_wdata, exp_data);
        @(negedge clk);
        check({tag, "_count"}, {16'b0, count}, exp_count);
        check({tag, "_we_low"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_full"}, {31'b0, full}, (exp_count == DEPTH) ? 32'd1 : 32'd0);
        check({tag, "_ready"}, {31'b0, in_ready}, (exp_count == DEPTH) ? 32'd0 : 32'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic illegal(input string tag, input logic [3:0] op, input logic [20:0] imm,
                           input int exp_count);
        send(op, 5'd1, 5'd2, 5'd3, imm);
        check({tag, "_enc_we"}, {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        check({tag, "_err"}, {31'b0, err}, 32'd1);
        check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_count"}, {16'b0, count}, exp_count);
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        nrst = 1'b0; restart = 1'b0; in_valid = 1'b0; mem_ack = 1'b1;
        in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 21'd0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", {16'b0, count}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);

        write_one("add", 4'd0, 5'd3, 5'd1, 5'd2, 21'd0, BASE, 32'h002081B3, 1);
        write_one("addi", 4'd6, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, BASE + 32'd4, 32'hFFF00093, 2);
        write_one("sw", 4'd8, 5'd0, 5'd2, 5'd5, 21'd8, BASE + 32'd8, 32'h00512423, 3);

        pulse_restart();
        check("rs1_count", {16'b0, count}, 32'd0);
        check("rs1_addr", mem_addr, BASE);

        // BNE with mem_ack held low for 5 cycles.
        mem_ack = 1'b0;
        send(4'd10, 5'd0, 5'd1, 5'd2, 21'h1FFFFC);
        wait_we(k);
        check("bne_lat", k, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("stall_we", {31'b0, mem_we}, 32'd1);
            check("stall_addr", mem_addr, BASE);
            check("stall_data", mem_wdata, 32'hFE209EE3);
            check("stall_count", {16'b0, count}, 32'd0);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        check("ack_cycle_count", {16'b0, count}, 32'd0);
        @(negedge clk);
        check("bne_count", {16'b0, count}, 32'd1);
        check("bne_we_low", {31'b0, mem_we}, 32'd0);
        write_one("jal", 4'd11, 5'd1, 5'd0, 5'd0, 21'd8, BASE + 32'd4, 32'h008000EF, 2);

        illegal("addi2048", 4'd6, 21'd2048, 2);
        pulse_restart();
        check("rs2_err", {31'b0, err}, 32'd0);
        illegal("beq_odd", 4'd9, 21'd3, 0);
        pulse_restart();
        illegal("op14", 4'd14, 21'd0, 0);

        write_one("f_add", 4'd0, 5'd3, 5'd1, 5'd2, 21'd0, BASE, 32'h002081B3, 1);
        check("err_sticky", {31'b0, err}, 32'd1);
        write_one("f_sub", 4'd1, 5'd5, 5'd6, 5'd7, 21'd0, BASE + 32'd4, 32'h407302B3, 2);
        write_one("f_lw", 4'd7, 5'd4, 5'd2, 5'd0, 21'd12, BASE + 32'd8, 32'h00C12203, 3);
        write_one("f_and", 4'd2, 5'd8, 5'd9, 5'd10, 21'd0, BASE + 32'd12, 32'h00A4F433, 4);

        in_op = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_we", {31'b0, mem_we}, 32'd0);
            check("full_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("full_count", {16'b0, count}, 32'd4);
        check("full_flag", {31'b0, full}, 32'd1);

        pulse_restart();
        check("rs3_count", {16'b0, count}, 32'd0);
        check("rs3_full", {31'b0, full}, 32'd0);
        check("rs3_err", {31'b0, err}, 32'd0);
        check("rs3_ready", {31'b0, in_ready}, 32'd1);
        write_one("post_rs", 4'd4, 5'd1, 5'd2, 5'd3, 21'd0, BASE, 32'h003140B3, 1);

        // restart aborts a pending write.
        mem_ack = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        wait_we(k);
        check("abort_addr", mem_addr, BASE + 32'd4);
        mem_ack = 1'b1;
        pulse_restart();
        check("abort_we", {31'b0, mem_we}, 32'd0);
        check("abort_count", {16'b0, count}, 32'd0);
        check("abort_addr2", mem_addr, BASE);
        write_one("after_abort", 4'd5, 5'd1, 5'd2, 5'd3, 21'd0, BASE, 32'h003120B3, 1);

        // Reset during a stalled write.
        mem_ack = 1'b0;
        send(4'd3, 5'd1, 5'd2, 5'd3, 21'd0);
        wait_we(k);
        check("rstw_we_before", {31'b0, mem_we}, 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        mem_ack = 1'b1;
        check("rstw_we", {31'b0, mem_we}, 32'd0);
        check("rstw_count", {16'b0, count}, 32'd0);
        check("rstw_addr", mem_addr, BASE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder and program loader for the single-cycle core, the encode-side counterpart of the control decoder. It accepts one instruction request at a time (operation, register fields, immediate) over a valid/ready handshake. It packs the request into a 32-bit RV32I word (R/I/S/B/J formats) and writes it into instruction memory at consecutive word addresses. Benches and boot logic use it to build programs in place.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH, 64, maximum words written before full (1..65535).
- clk  input  1  clock; all logic on rising edge.
- nrst  input  1  synchronous reset, active-low.
- restart  input  1  one-cycle pulse: rewind to BASE_ADDR, clear count/err/full.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 JAL, 12 JALR, 13-15 illegal.
- in_rd, in_rs1, in_rs2  input  5 each  register numbers.
- in_imm  input  21  signed immediate (byte offset for branch/JAL).
- mem_we  output  1  write strobe, held until mem_ack.
- mem_ack  input  1  memory accepted the write this cycle.
- mem_addr  output  32  byte address of the current write.
- mem_wdata  output  32  encoded instruction.
- count  output  16  words successfully written.
- err  output  1  sticky: a rejected request occurred.
- full  output  1  count == DEPTH.

## Operation
- FSM states: IDLE, ENC, WRITE, FULL.
- IDLE: in_ready=1. On in_valid, latch all in_* fields and go to ENC.
- ENC: register the encoded word and a legal flag.
  - Illegal: set err and return to IDLE; no write, count and address unchanged.
  - Legal: go to WRITE.
- WRITE: mem_we=1 with stable mem_addr/mem_wdata until mem_ack. In the ack cycle, count+1 and address+4. Then go to FULL if the new count == DEPTH, else IDLE.
- FULL: full=1, in_ready=0. Leave only via restart or reset.
- Encoding, RV32I standard:
  - R (op 0-5): opcode 0110011, funct3 ADD/SUB 000, SLT 010, XOR 100, OR 110, AND 111. funct7 is 0100000 for SUB, 0 otherwise.
  - I: ADDI 0010011/000, LW 0000011/010, JALR 1100111/000. imm[11:0] goes to bits 31:20.
  - S: SW 0100011/010. imm[11:5] to 31:25, imm[4:0] to 11:7.
  - B: BEQ 000, BNE 001, opcode 1100011. imm[12|10:5] to 31:25, imm[4:1|11] to 11:7.
  - J: JAL 1101111. imm[20|10:1|11|19:12] to 31:12.
  - Fields a format does not use are ignored; rd is ignored for S/B.
- Legality checks (fail sets err):
  - I/S: in_imm must lie in -2048..2047.
  - B: in_imm must lie in -4096..4094 and be even.
  - J: in_imm must be even; the full 21-bit range is legal.
  - op 13-15 is illegal.
- restart takes priority over all state activity. It aborts a pending WRITE: mem_we is low next cycle and the word is not counted. The FSM returns to IDLE next cycle.

## Timing
- Reset (nrst=0 at edge) values: state IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0, full=0.
- Request accepted at edge N (in_valid & in_ready). ENC occupies cycle N+1. mem_we rises at N+2.
- With mem_ack tied high: one write per 3 cycles, and in_ready is high again at N+3.
- mem_ack is ignored whenever mem_we=0.
- err persists across later legal writes until restart or reset.
- Reset mid-WRITE: no increment, mem_we low after the edge.
- Address wrap: mem_addr is plain 32-bit +4 arithmetic with no saturation. Full always stops writes at DEPTH.

## Test plan
- ADD rd=3 rs1=1 rs2=2 -> one write, mem_addr=BASE, mem_wdata=0x002081B3, count=1, mem_we rises 2 cycles after accept.
- ADDI rd=1 rs1=0 imm=-1, then SW rs1=2 rs2=5 imm=8 -> 0xFFF00093 at BASE, 0x00512423 at BASE+4.
- BNE rs1=1 rs2=2 imm=-4 -> 0xFE209EE3. JAL rd=1 imm=8 -> 0x008000EF.
- Hold mem_ack low 5 cycles -> mem_we, addr and data stable for all 5 cycles; count increments only in the ack cycle.
- ADDI imm=2048, BEQ imm=3, op=14 -> each sets err, no mem_we, count unchanged; a following legal request writes normally with err still 1.
- DEPTH=4: four writes -> full=1, in_ready=0, further in_valid ignored. restart -> count=0, full=0, err=0, next write at BASE.
